// File: rtl/latch_wr_pkg.sv
// Shared types and helpers for the latch write-pulse sequencer.
//   wr_state_e : sequencer phases (IDLE, SETUP, PULSE, HOLD, DONE)
//   cnt_width  : width of the phase counter that covers the longest phase
package latch_wr_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } wr_state_e;

    // Bits needed to hold a reload value of max(setup, pulse, hold) - 1 without wrapping.
    function automatic int cnt_width(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
        int m;
        m = (setup_cyc > pulse_cyc) ? setup_cyc : pulse_cyc;
        m = (hold_cyc > m) ? hold_cyc : m;
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/latch_wr_gn_dec.sv
// Registered one-hot-low GN decoder for the latch bank enables.
//   clk, rst : clock and synchronous active-high reset
//   bank     : selected bank index (may be out of range when NUM_BANKS is not 2^n)
//   gn_en    : the next cycle is a GN-low pulse cycle
//   err_en   : the next cycle is the completion cycle
//   gn       : per-bank active-low enable, flop-driven, at most one bit low
//   err      : flop-driven out-of-range flag, meaningful alongside done
module latch_wr_gn_dec
    import latch_wr_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int BANK_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BANK_W-1:0]    bank,
    input  logic                 gn_en,
    input  logic                 err_en,
    output logic [NUM_BANKS-1:0] gn,
    output logic                 err
);

    localparam logic [BANK_W:0] NB_LIM = NUM_BANKS[BANK_W:0];

    logic [NUM_BANKS-1:0] gn_nx_s;
    logic [NUM_BANKS-1:0] gn_r;
    logic                 err_nx_s;
    logic                 err_r;
    logic                 out_rng_s;

    // Decode the next GN pattern; an out-of-range bank keeps every line high.
    always_comb begin
        out_rng_s = ({1'b0, bank} >= NB_LIM);
        gn_nx_s   = {NUM_BANKS{1'b1}};
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (gn_en && !out_rng_s && (bank == i[BANK_W-1:0])) begin
                gn_nx_s[i] = 1'b0;
            end else begin
                gn_nx_s[i] = 1'b1;
            end
        end
        err_nx_s = err_en & out_rng_s;
    end

    // GN and err registers so the latch-facing lines never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            gn_r  <= {NUM_BANKS{1'b1}};
            err_r <= 1'b0;
        end else begin
            gn_r  <= gn_nx_s;
            err_r <= err_nx_s;
        end
    end

    assign gn  = gn_r;
    assign err = err_r;

endmodule

// File: rtl/latch_wr_seq.sv
// Write-pulse sequencer driving a bank of active-low transparent latches.
// A request is captured, D_OUT is presented, GN of the target bank is pulsed
// low after SETUP_CYC cycles for PULSE_CYC cycles, data is held HOLD_CYC more
// cycles, then done (with err for an out-of-range bank) pulses for one cycle.
//   CK, RST  : clock and synchronous active-high reset
//   in_valid / in_ready / in_bank / in_data : request handshake
//   D_OUT    : shared latch data bus (flop-driven)
//   GN       : per-bank active-low latch enable (flop-driven)
//   done/err : completion pulse and out-of-range flag
module latch_wr_seq
    import latch_wr_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_BANKS = 4,
    parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BANK_W-1:0]    in_bank,
    input  logic [WIDTH-1:0]     in_data,
    output logic [WIDTH-1:0]     D_OUT,
    output logic [NUM_BANKS-1:0] GN,
    output logic                 done,
    output logic                 err
);

    localparam int CNT_W    = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam int ZERO_I   = 0;
    localparam int ONE_I    = 1;
    localparam int SETUP_M1 = SETUP_CYC - 1;
    localparam int PULSE_M1 = PULSE_CYC - 1;
    localparam int HOLD_M1  = HOLD_CYC - 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = ZERO_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE  = ONE_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] SETUP_LD = SETUP_M1[CNT_W-1:0];
    localparam logic [CNT_W-1:0] PULSE_LD = PULSE_M1[CNT_W-1:0];
    localparam logic [CNT_W-1:0] HOLD_LD  = HOLD_M1[CNT_W-1:0];

    wr_state_e          state_r;
    wr_state_e          state_nx;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx;
    logic [BANK_W-1:0]  bank_r;
    logic [BANK_W-1:0]  bank_nx;
    logic [WIDTH-1:0]   dout_r;
    logic [WIDTH-1:0]   dout_nx;
    logic               done_r;
    logic               gn_en_s;
    logic               err_en_s;

    // Next-state, counter and capture logic; data/bank only change on a transfer.
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        bank_nx  = bank_r;
        dout_nx  = dout_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nx = SETUP;
                    cnt_nx   = SETUP_LD;
                    bank_nx  = in_bank;
                    dout_nx  = in_data;
                end else begin
                    state_nx = IDLE;
                end
            end
            SETUP: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nx = PULSE;
                    cnt_nx   = PULSE_LD;
                end else begin
                    cnt_nx = cnt_r - CNT_ONE;
                end
            end
            PULSE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nx = HOLD;
                    cnt_nx   = HOLD_LD;
                end else begin
                    cnt_nx = cnt_r - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nx = DONE;
                    cnt_nx   = CNT_ZERO;
                end else begin
                    cnt_nx = cnt_r - CNT_ONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = CNT_ZERO;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, captured request and done pulse registers.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            bank_r  <= {BANK_W{1'b0}};
            dout_r  <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            bank_r  <= bank_nx;
            dout_r  <= dout_nx;
            done_r  <= (state_nx == DONE);
        end
    end

    // GN and err are registered from the next state so they align with the phases.
    assign gn_en_s  = (state_nx == PULSE);
    assign err_en_s = (state_nx == DONE);

    latch_wr_gn_dec #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W)
    ) u_gn_dec (
        .clk    (CK),
        .rst    (RST),
        .bank   (bank_r),
        .gn_en  (gn_en_s),
        .err_en (err_en_s),
        .gn     (GN),
        .err    (err)
    );

    assign in_ready = (state_r == IDLE);
    assign D_OUT    = dout_r;
    assign done     = done_r;

endmodule
